// File: rtl/cplm_reg_seq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cplm_reg_seq_if : command valid/ready channel into the register sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
interface cplm_reg_seq_if #(
  parameter int DATA_W = 4,
  parameter int REP_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic [REP_W-1:0]  cmd_rep;

  modport master (output cmd_valid, cmd_op, cmd_data, cmd_rep, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_data, cmd_rep, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/cplm_reg_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cplm_reg_seq : FIFO-buffered replay of S1/S0/data commands, with shadow copy
// Revision 1.0
// ---------------------------------------------------------------------------
module cplm_reg_seq #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int REP_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  cplm_reg_seq_if.slave          cmd,
  output logic                   S1,
  output logic                   S0,
  output logic [DATA_W-1:0]      parallel_data,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [DATA_W-1:0]      shadow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 2 + DATA_W + REP_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t            state;
  logic [ENT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [REP_W-1:0]  rep_cnt;
  logic              push;
  logic              pop;
  logic [1:0]        head_op;
  logic [DATA_W-1:0] head_data;
  logic [REP_W-1:0]  head_rep;

  // Ready looks only at the occupancy: a full FIFO refuses even on a pop edge.
  assign cmd.cmd_ready = (count < DEPTH_C);
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign pop           = (count != '0) && ((state == IDLE) || (rep_cnt == '0));
  assign {head_op, head_data, head_rep} = mem[rd_ptr];
  assign busy          = (state == EXEC) || (count != '0);
  assign fifo_count    = count;

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= {cmd.cmd_op, cmd.cmd_data, cmd.cmd_rep};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      S1            <= 1'b0;
      S0            <= 1'b0;
      parallel_data <= '0;
      done          <= 1'b0;
      rep_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state         <= EXEC;
            {S1, S0}      <= head_op;
            parallel_data <= head_data;
            rep_cnt       <= head_rep;
            done          <= (head_rep == '0);
          end else begin
            {S1, S0}      <= 2'b00;
            parallel_data <= '0;
            done          <= 1'b0;
          end
        end
        EXEC: begin
          if (rep_cnt != '0) begin
            rep_cnt <= rep_cnt - 1'b1;
            done    <= (rep_cnt == REP_W'(1));
          end else if (pop) begin
            // Chain straight into the next command so no hold cycle appears.
            {S1, S0}      <= head_op;
            parallel_data <= head_data;
            rep_cnt       <= head_rep;
            done          <= (head_rep == '0);
          end else begin
            state         <= IDLE;
            {S1, S0}      <= 2'b00;
            parallel_data <= '0;
            done          <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Mirrors the downstream register, which sees the same registered controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
    end else begin
      case ({S1, S0})
        2'b01:   shadow <= ~shadow;
        2'b10:   shadow <= parallel_data;
        2'b11:   shadow <= '0;
        default: shadow <= shadow;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cplm_reg_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cplm_reg_seq : directed and random checks against a schedule-based model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_cplm_reg_seq;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 4;
  localparam int REP_W  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cplm_reg_seq_if #(.DATA_W(DATA_W), .REP_W(REP_W)) cmd ();

  logic        S1, S0, busy, done;
  logic [3:0]  parallel_data, shadow;
  logic [2:0]  fifo_count;

  cplm_reg_seq #(.DATA_W(DATA_W), .DEPTH(DEPTH), .REP_W(REP_W)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .S1(S1), .S0(S0),
    .parallel_data(parallel_data), .busy(busy), .done(done),
    .fifo_count(fifo_count), .shadow(shadow)
  );

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] data;
    logic [3:0] rep;
  } cmd_t;

  // Model: queued commands plus the drive window [start, cur_end] of the active one.
  cmd_t       q[$];
  int         cyc = 0;
  int         cur_end = -1;
  logic [1:0] cur_op = 2'b00;
  logic [3:0] cur_data = 4'h0;
  logic [1:0] m_op = 2'b00;
  logic [3:0] m_pd = 4'h0;
  logic [3:0] m_shadow = 4'h0;
  logic       m_done = 1'b0;
  logic       last_push = 1'b0;
  int         compared = 0;
  int         mismatched = 0;

  function automatic logic m_busy();
    return (cyc <= cur_end) || (q.size() != 0);
  endfunction

  function automatic logic [15:0] expv();
    return {m_op, m_pd, m_done, m_busy(), 3'(q.size()), m_shadow, (q.size() < DEPTH)};
  endfunction

  function automatic logic [15:0] obs();
    return {S1, S0, parallel_data, done, busy, fifo_count, shadow, cmd.cmd_ready};
  endfunction

  task automatic tick(input logic r, input logic v, input logic [1:0] op,
                      input logic [3:0] data, input logic [3:0] rep);
    cmd_t c;
    rst           = r;
    cmd.cmd_valid = v;
    cmd.cmd_op    = op;
    cmd.cmd_data  = data;
    cmd.cmd_rep   = rep;
    cyc++;
    last_push = 1'b0;
    if (r) begin
      q.delete();
      cur_end  = -1;
      m_op     = 2'b00;
      m_pd     = 4'h0;
      m_shadow = 4'h0;
      m_done   = 1'b0;
    end else begin
      case (m_op)
        2'b01:   m_shadow = ~m_shadow;
        2'b10:   m_shadow = m_pd;
        2'b11:   m_shadow = 4'h0;
        default: m_shadow = m_shadow;
      endcase
      last_push = v && (q.size() < DEPTH);
      if (q.size() > 0 && cyc > cur_end) begin
        c        = q.pop_front();
        cur_op   = c.op;
        cur_data = c.data;
        cur_end  = cyc + int'(c.rep);
      end
      if (last_push) begin
        c = {op, data, rep};
        q.push_back(c);
      end
      if (cyc <= cur_end) begin
        m_op   = cur_op;
        m_pd   = cur_data;
        m_done = (cyc == cur_end);
      end else begin
        m_op   = 2'b00;
        m_pd   = 4'h0;
        m_done = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) begin
      tick(1'b1, 1'b1, 2'b10, 4'h7, 4'h0);
      compared++;
      if (obs() !== expv()) begin
        mismatched++;
        $display("FAIL reset_vec cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
    end
    compared++;
    if ({S1, S0, parallel_data, busy, fifo_count, shadow, cmd.cmd_ready} !== {2'b00, 4'h0, 1'b0, 3'd0, 4'h0, 1'b1}) begin
      mismatched++;
      $display("FAIL reset_const got=%b exp=%b", {S1, S0, parallel_data, busy, fifo_count, shadow, cmd.cmd_ready},
               {2'b00, 4'h0, 1'b0, 3'd0, 4'h0, 1'b1});
    end
    tick(1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
    compared++;
    if ({S1, S0, fifo_count, busy} !== 6'b0) begin
      mismatched++;
      $display("FAIL reset_nothing_queued got=%b exp=000000", {S1, S0, fifo_count, busy});
    end
  endtask

  task automatic test_single_load();
    tick(1'b0, 1'b1, 2'b10, 4'hA, 4'h0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick(1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
      compared++;
      if (obs() !== expv()) begin
        mismatched++;
        $display("FAIL single_load_vec cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
      if (i == 0) tick(1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
      if (i == 0) begin
        compared++;
        if ({S1, S0, parallel_data, done} !== {2'b10, 4'hA, 1'b1}) begin
          mismatched++;
          $display("FAIL single_load_drive got=%b exp=%b", {S1, S0, parallel_data, done}, {2'b10, 4'hA, 1'b1});
        end
      end
    end
    compared++;
    if ({S1, S0, parallel_data, shadow} !== {2'b00, 4'h0, 4'hA}) begin
      mismatched++;
      $display("FAIL single_load_after got=%h exp=%h", {S1, S0, parallel_data, shadow}, {2'b00, 4'h0, 4'hA});
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] sh_exp [4];
    logic [1:0] op_exp [5];
    int dones = 0;
    sh_exp = '{4'h5, 4'hA, 4'h5, 4'hA};
    op_exp = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b00};
    for (int i = 1; i <= 7; i++) begin
      if (i == 1)      tick(1'b0, 1'b1, 2'b10, 4'h5, 4'h0);
      else if (i == 2) tick(1'b0, 1'b1, 2'b01, 4'h0, 4'h2);
      else             tick(1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
      compared++;
      if (obs() !== expv()) begin
        mismatched++;
        $display("FAIL b2b_vec cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
      if (done === 1'b1) dones++;
      if (i >= 2 && i <= 6) begin
        compared++;
        if ({S1, S0} !== op_exp[i-2]) begin
          mismatched++;
          $display("FAIL b2b_op step=%0d got=%b exp=%b", i, {S1, S0}, op_exp[i-2]);
        end
      end
      if (i >= 3 && i <= 6) begin
        compared++;
        if (shadow !== sh_exp[i-3]) begin
          mismatched++;
          $display("FAIL b2b_shadow step=%0d got=%h exp=%h", i, shadow, sh_exp[i-3]);
        end
      end
    end
    compared++;
    if (dones != 2) begin
      mismatched++;
      $display("FAIL b2b_done_count got=%0d exp=2", dones);
    end
  endtask

  task automatic test_full_fifo();
    int n;
    int dones = 0;
    logic saw_not_ready = 1'b0;
    tick(1'b0, 1'b1, 2'b01, 4'h0, 4'hF);
    if (done === 1'b1) dones++;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] d;
      d = 4'($urandom_range(0, 15));
      n = 0;
      do begin
        tick(1'b0, 1'b1, 2'b10, d, 4'h0);
        n++;
        compared++;
        if (obs() !== expv()) begin
          mismatched++;
          $display("FAIL full_vec cyc=%0d got=%h exp=%h", cyc, obs(), expv());
        end
        if (cmd.cmd_ready === 1'b0) saw_not_ready = 1'b1;
        if (done === 1'b1) dones++;
      end while (!last_push && n < 40);
      if (!last_push) begin
        mismatched++;
        $display("FAIL full_accept_timeout load=%0d got=stuck exp=accepted", k);
      end
    end
    n = 0;
    while (m_busy() && n < 60) begin
      tick(1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
      n++;
      compared++;
      if (obs() !== expv()) begin
        mismatched++;
        $display("FAIL full_drain_vec cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
      if (done === 1'b1) dones++;
    end
    compared++;
    if (!saw_not_ready || dones != 6 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL full_summary got=not_ready:%0b dones:%0d busy:%b exp=1/6/0", saw_not_ready, dones, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic saw_op = 1'b0;
    tick(1'b0, 1'b1, 2'b01, 4'h0, 4'hF);
    tick(1'b0, 1'b1, 2'b10, 4'h3, 4'h0);
    tick(1'b0, 1'b1, 2'b11, 4'h0, 4'h0);
    repeat (4) tick(1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
    compared++;
    if ({S1, S0, fifo_count} !== {2'b01, 3'd2}) begin
      mismatched++;
      $display("FAIL rmid_before got=%b exp=%b", {S1, S0, fifo_count}, {2'b01, 3'd2});
    end
    tick(1'b1, 1'b0, 2'b00, 4'h0, 4'h0);
    compared++;
    if ({S1, S0, fifo_count, shadow} !== 9'b0) begin
      mismatched++;
      $display("FAIL rmid_after got=%b exp=%b", {S1, S0, fifo_count, shadow}, 9'b0);
    end
    repeat (25) begin
      tick(1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
      compared++;
      if (obs() !== expv()) begin
        mismatched++;
        $display("FAIL rmid_vec cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
      if ({S1, S0} !== 2'b00) saw_op = 1'b1;
    end
    compared++;
    if (saw_op) begin
      mismatched++;
      $display("FAIL rmid_dropped got=executed exp=none");
    end
  endtask

  task automatic test_clear_hold();
    logic [1:0] op_exp [7];
    logic [3:0] sh_exp [6];
    op_exp = '{2'b10, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    sh_exp = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    for (int i = 1; i <= 10; i++) begin
      if (i == 1)      tick(1'b0, 1'b1, 2'b10, 4'hF, 4'h0);
      else if (i == 2) tick(1'b0, 1'b1, 2'b11, 4'h0, 4'h1);
      else if (i == 3) tick(1'b0, 1'b1, 2'b00, 4'h0, 4'h3);
      else             tick(1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
      compared++;
      if (obs() !== expv()) begin
        mismatched++;
        $display("FAIL clrhold_vec cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
      if (i >= 2 && i <= 8) begin
        compared++;
        if ({S1, S0} !== op_exp[i-2]) begin
          mismatched++;
          $display("FAIL clrhold_op step=%0d got=%b exp=%b", i, {S1, S0}, op_exp[i-2]);
        end
      end
      if (i >= 3 && i <= 8) begin
        compared++;
        if (shadow !== sh_exp[i-3]) begin
          mismatched++;
          $display("FAIL clrhold_shadow step=%0d got=%h exp=%h", i, shadow, sh_exp[i-3]);
        end
      end
    end
  endtask

  task automatic test_random();
    int n;
    for (int i = 0; i < 600; i++) begin
      logic       r, v;
      logic [1:0] op;
      logic [3:0] d, rp;
      r  = ($urandom_range(0, 99) == 0);
      v  = ($urandom_range(0, 1) == 1);
      op = 2'($urandom_range(0, 3));
      d  = (op == 2'b10) ? 4'($urandom_range(0, 15)) : 4'h0;
      rp = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      tick(r, v, op, d, rp);
      compared++;
      if (obs() !== expv()) begin
        mismatched++;
        $display("FAIL random_vec cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
    end
    n = 0;
    while (m_busy() && n < 100) begin
      tick(1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
      n++;
      compared++;
      if (obs() !== expv()) begin
        mismatched++;
        $display("FAIL random_drain cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_back_to_back();
    test_full_fifo();
    test_reset_mid();
    test_clear_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
